// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter.
// Imported by every file of the UART slice.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    localparam int CLK_HZ = 50_000_000;
    localparam int BAUD   = 115_200;
    localparam int DEFAULT_CLKS_PER_BIT = CLK_HZ / BAUD;

    // Unknown parity codes fall back to no parity bit.
    function automatic logic parity_enabled(input int ptype);
        return (ptype == PARITY_ODD) || (ptype == PARITY_EVEN);
    endfunction

    // Word is zero-extended by the caller; zeros do not change the XOR.
    function automatic logic parity_bit(input logic [8:0] word,
                                        input int ptype);
        return (ptype == PARITY_ODD) ? ~^word : ^word;
    endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period counter for the UART transmitter.
// Produces a registered end-of-bit strobe.
module uart_baud_counter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic run,
    input  logic busy_d,
    output logic tick
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    // Count restarts on a handshake, wraps each bit, rests at 0 when idle.
    always_comb begin
        cnt_d = '0;
        if (start) begin
            cnt_d = '0;
        end else if (run && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
        tick_d = busy_d && (cnt_d == LAST);
    end

    // Counter and strobe registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: valid/ready byte in, LSB-first serial frame out.
// Frame is start, BITS_N data bits, optional parity, one stop bit.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int BITS_N       = 8,
    parameter int PARITY_TYPE  = PARITY_NONE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BITS_N-1:0] data_tx,
    input  logic              valid,
    output logic              ready,
    output logic              uart_out,
    output logic              baud_trigger
);

    localparam logic PAR_EN = parity_enabled(PARITY_TYPE);
    localparam int   BW     = $clog2(BITS_N);
    localparam logic [BW-1:0] LAST_BIT = BW'(BITS_N - 1);

    uart_state_e       state_q, state_d;
    logic [BITS_N-1:0] shift_q, shift_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic              par_q, par_d;
    logic              out_q, out_d;
    logic              ready_q, ready_d;
    logic              handshake;
    logic              bit_end;

    assign handshake = valid && ready_q;

    uart_baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk   (clk),
        .rst   (rst),
        .start (handshake),
        .run   (state_q != IDLE),
        .busy_d(state_d != IDLE),
        .tick  (bit_end)
    );

    // Next state; the line only moves at a handshake or a bit boundary.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        par_d   = par_q;
        out_d   = out_q;
        ready_d = ready_q;
        unique case (state_q)
            IDLE: begin
                if (handshake) begin
                    shift_d = data_tx;
                    par_d   = parity_bit(9'(data_tx), PARITY_TYPE);
                    bit_d   = '0;
                    out_d   = 1'b0;
                    ready_d = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    out_d   = shift_q[0];
                    shift_d = shift_q >> 1;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_q == LAST_BIT) begin
                        if (PAR_EN) begin
                            out_d   = par_q;
                            state_d = PARITY;
                        end else begin
                            out_d   = 1'b1;
                            state_d = STOP;
                        end
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        out_d   = shift_q[0];
                        shift_d = shift_q >> 1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    out_d   = 1'b1;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    out_d   = 1'b1;
                    ready_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                out_d   = 1'b1;
                ready_d = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            par_q   <= 1'b0;
            out_q   <= 1'b1;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            par_q   <= par_d;
            out_q   <= out_d;
            ready_q <= ready_d;
        end
    end

    assign ready        = ready_q;
    assign uart_out     = out_q;
    assign baud_trigger = bit_end;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter across four parameter sets.
// Lines are sampled 1 time unit after each rising edge.
module tb_uart_transmitter;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic       v0, v1, v2, v3;
    logic [7:0] d0, d1, d2;
    logic [6:0] d3;
    logic       uo0, uo1, uo2, uo3;
    logic       rdy0, rdy1, rdy2, rdy3;
    logic       bt0, bt1, bt2, bt3;
    logic [3:0] uo, rdy, bt;

    int n_assert = 0;
    int n_fail   = 0;

    assign uo  = {uo3, uo2, uo1, uo0};
    assign rdy = {rdy3, rdy2, rdy1, rdy0};
    assign bt  = {bt3, bt2, bt1, bt0};

    always #5 clk = ~clk;

    uart_transmitter u0 (
        .clk(clk), .rst(rst), .data_tx(d0), .valid(v0),
        .ready(rdy0), .uart_out(uo0), .baud_trigger(bt0)
    );

    uart_transmitter #(
        .CLKS_PER_BIT(4), .BITS_N(8), .PARITY_TYPE(2)
    ) u1 (
        .clk(clk), .rst(rst), .data_tx(d1), .valid(v1),
        .ready(rdy1), .uart_out(uo1), .baud_trigger(bt1)
    );

    uart_transmitter #(
        .CLKS_PER_BIT(4), .BITS_N(8), .PARITY_TYPE(1)
    ) u2 (
        .clk(clk), .rst(rst), .data_tx(d2), .valid(v2),
        .ready(rdy2), .uart_out(uo2), .baud_trigger(bt2)
    );

    uart_transmitter #(
        .CLKS_PER_BIT(2), .BITS_N(7), .PARITY_TYPE(0)
    ) u3 (
        .clk(clk), .rst(rst), .data_tx(d3), .valid(v3),
        .ready(rdy3), .uart_out(uo3), .baud_trigger(bt3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input int u, input logic v, input logic [8:0] d);
        case (u)
            0: begin v0 = v; d0 = d[7:0]; end
            1: begin v1 = v; d1 = d[7:0]; end
            2: begin v2 = v; d2 = d[7:0]; end
            default: begin v3 = v; d3 = d[6:0]; end
        endcase
    endtask

    // One handshake, then watch the whole frame plus a few idle cycles.
    // exp holds the line value per bit, first bit (start) in bit 0.
    task automatic frame(input int u, input int cpb, input int nb,
                         input logic [8:0] d, input logic [15:0] exp,
                         input int inj_c, input logic [8:0] inj_d,
                         input string tag);
        logic [15:0] bits;
        int total, nbt, first_bt, last_bt, bad_sp, rlow, idle_bad;
        total = nb * cpb;
        bits = '0;
        nbt = 0; first_bt = -1; last_bt = -1;
        bad_sp = 0; rlow = 0; idle_bad = 0;
        set_in(u, 1'b1, d);
        step();
        set_in(u, 1'b0, d);
        chk({tag, "_start"}, {30'd0, uo[u], rdy[u]}, 32'd0);
        for (int c = 0; c < total + 4; c++) begin
            if (c < total && (c % cpb) == cpb / 2)
                bits[c / cpb] = uo[u];
            if (bt[u]) begin
                nbt++;
                if (first_bt < 0) first_bt = c;
                else if (c - last_bt != cpb) bad_sp++;
                last_bt = c;
            end
            if (c < total && !rdy[u]) rlow++;
            if (c >= total && (!rdy[u] || !uo[u])) idle_bad++;
            if (c == inj_c) set_in(u, 1'b1, inj_d);
            else if (c == inj_c + 1) set_in(u, 1'b0, inj_d);
            step();
        end
        chk({tag, "_bits"}, 32'(bits), 32'(exp));
        chk({tag, "_ntrig"}, nbt, nb);
        chk({tag, "_first_trig"}, first_bt, cpb - 1);
        chk({tag, "_trig_spacing"}, bad_sp, 0);
        chk({tag, "_ready_low"}, rlow, total);
        chk({tag, "_idle_after"}, idle_bad, 0);
    endtask

    initial begin
        logic [9:0] f1, f2;
        int hs2;
        logic drop;

        v0 = 0; v1 = 0; v2 = 0; v3 = 0;
        d0 = '0; d1 = '0; d2 = '0; d3 = '0;
        rst = 1'b0;
        step();
        step();
        chk("reset_uart_out", 32'(uo), 32'hF);
        chk("reset_ready", 32'(rdy), 32'hF);
        chk("reset_trig", 32'(bt), 32'h0);
        rst = 1'b1;
        step();

        // Abort a frame with an asynchronous reset.
        set_in(0, 1'b1, 9'h07B);
        step();
        set_in(0, 1'b0, 9'h07B);
        repeat (1000) step();
        chk("midframe_busy", 32'(rdy[0]), 32'd0);
        rst = 1'b0;
        #1;
        chk("midframe_rst_out", 32'(uo[0]), 32'd1);
        chk("midframe_rst_ready", 32'(rdy[0]), 32'd1);
        chk("midframe_rst_trig", 32'(bt[0]), 32'd0);
        repeat (3) step();
        rst = 1'b1;
        step();

        // 0x7B 8N1: 0,1,1,0,1,1,1,1,0,1 -> 0x2F6
        frame(0, 434, 10, 9'h07B, 16'h02F6, -1, 9'h000, "8n1");
        // 0x31 even parity 1 -> 0x662 ; odd parity 0 -> 0x462
        frame(1, 4, 11, 9'h031, 16'h0662, -1, 9'h000, "even");
        frame(2, 4, 11, 9'h031, 16'h0462, -1, 9'h000, "odd");
        // 0x55 even parity 0 -> 0x4AA ; 0xAA pulse at cycle 10 ignored
        frame(1, 4, 11, 9'h055, 16'h04AA, 10, 9'h0AA, "busy");

        // Back-to-back with valid held: 0x22 -> 0x244, 0x54 -> 0x2A8
        f1 = '0;
        f2 = '0;
        hs2 = -1;
        drop = 1'b0;
        set_in(0, 1'b1, 9'h022);
        step();
        set_in(0, 1'b1, 9'h054);
        for (int c = 0; c < 2 * 4340 + 20; c++) begin
            if (c < 4340 && (c % 434) == 217)
                f1[c / 434] = uo[0];
            if (hs2 >= 0 && c >= hs2 && c - hs2 < 4340 &&
                ((c - hs2) % 434) == 217)
                f2[(c - hs2) / 434] = uo[0];
            if (hs2 < 0 && c > 0 && rdy[0]) begin
                hs2 = c + 1;
                drop = 1'b1;
            end
            step();
            if (drop) begin
                set_in(0, 1'b0, 9'h054);
                drop = 1'b0;
            end
            if (hs2 >= 0 && c > hs2 + 4340) break;
        end
        set_in(0, 1'b0, 9'h054);
        chk("b2b_first", 32'(f1), 32'h244);
        chk("b2b_second", 32'(f2), 32'h2A8);
        chk("b2b_gap", hs2, 4341);

        // 7 data bits, 2 clocks per bit: 0x7F -> 0x1FE
        frame(3, 2, 9, 9'h07F, 16'h01FE, -1, 9'h000, "w7");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
